// File: rtl/suprloco_video_pkg.sv
// Shared raster constants and pixel/pattern types for the SuprLoco video output path.
package suprloco_video_pkg;

    localparam int unsigned H_ACTIVE = 256;
    localparam int unsigned H_TOTAL  = 320;
    localparam int unsigned V_ACTIVE = 224;
    localparam int unsigned V_TOTAL  = 264;
    localparam int unsigned HS_START = 272;
    localparam int unsigned HS_END   = 303;
    localparam int unsigned VS_START = 232;
    localparam int unsigned VS_END   = 235;

    typedef enum logic [1:0] {
        PatFb      = 2'd0,
        PatBars    = 2'd1,
        PatChecker = 2'd2,
        PatBlack   = 2'd3
    } pattern_t;

    typedef logic [8:0] rgb333_t;

    typedef struct packed {
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       vblank;
        logic       frame_start;
        logic [7:0] x;
        logic [7:0] y;
    } raster_tag_t;

    function automatic rgb333_t pattern_pixel(pattern_t pat, logic [2:0] bar, logic chk,
                                              rgb333_t fb);
        rgb333_t pix;
        pix = '0;
        case (pat)
            PatFb:      pix = fb;
            PatBars:    pix = {{3{bar[2]}}, {3{bar[1]}}, {3{bar[0]}}};
            PatChecker: pix = chk ? 9'h1ff : 9'h000;
            default:    pix = '0;
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/suprloco_video_delay.sv
// Tick-enabled shift register that keeps raster flags/coordinates aligned with pipelined data.
module suprloco_video_delay #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/suprloco_video_tx.sv
// Video output stage: pixel-enable divider, raster counters, framebuffer fetch and
// test-pattern generation driving the video bus.
module suprloco_video_tx
    import suprloco_video_pkg::*;
#(
    parameter int unsigned CEN_DIV    = 8,
    parameter int unsigned H_ACTIVE   = suprloco_video_pkg::H_ACTIVE,
    parameter int unsigned H_TOTAL    = suprloco_video_pkg::H_TOTAL,
    parameter int unsigned V_ACTIVE   = suprloco_video_pkg::V_ACTIVE,
    parameter int unsigned V_TOTAL    = suprloco_video_pkg::V_TOTAL,
    parameter int unsigned FB_LATENCY = 2,
    parameter int unsigned HS_START   = suprloco_video_pkg::HS_START,
    parameter int unsigned HS_END     = suprloco_video_pkg::HS_END,
    parameter int unsigned VS_START   = suprloco_video_pkg::VS_START,
    parameter int unsigned VS_END     = suprloco_video_pkg::VS_END
) (
    input  logic        i_EMU_MCLK,
    input  logic        i_EMU_MRST,
    input  logic [1:0]  i_PATTERN,
    output logic [15:0] o_FB_ADDR,
    output logic        o_FB_RD,
    input  logic [8:0]  i_FB_DATA,
    output logic        o_VIDEO_CEN,
    output logic        o_VIDEO_EN,
    output logic [2:0]  o_VIDEO_R,
    output logic [2:0]  o_VIDEO_G,
    output logic [2:0]  o_VIDEO_B,
    output logic        o_HSYNC,
    output logic        o_VSYNC,
    output logic        o_VBLANK,
    output logic        o_FRAME_START
);

    logic [2:0]  div_q, div_d;
    logic        cen_q;
    logic [8:0]  h_q, v_q;
    pattern_t    pattern_q;
    raster_tag_t fetch_tag, out_tag;
    rgb333_t     pix;

    always_comb begin
        div_d = (div_q == 3'(CEN_DIV - 1)) ? 3'd0 : div_q + 3'd1;

        fetch_tag.active      = (h_q < 9'(H_ACTIVE)) && (v_q < 9'(V_ACTIVE));
        fetch_tag.hsync       = (h_q >= 9'(HS_START)) && (h_q <= 9'(HS_END));
        fetch_tag.vsync       = (v_q >= 9'(VS_START)) && (v_q <= 9'(VS_END));
        fetch_tag.vblank      = (v_q >= 9'(V_ACTIVE));
        fetch_tag.frame_start = (h_q == 9'd0) && (v_q == 9'd0);
        fetch_tag.x           = h_q[7:0];
        fetch_tag.y           = v_q[7:0];

        pix = pattern_pixel(pattern_q, out_tag.x[7:5], out_tag.x[3] ^ out_tag.y[3], i_FB_DATA);
    end

    // Coordinates ride along in full so later layers can align to them.
    logic unused_tag_bits;
    assign unused_tag_bits = ^{out_tag.x[4], out_tag.x[2:0], out_tag.y[7:4], out_tag.y[2:0]};

    suprloco_video_delay #(
        .DEPTH(FB_LATENCY),
        .WIDTH($bits(raster_tag_t))
    ) u_delay (
        .clk_i(i_EMU_MCLK),
        .rst_i(i_EMU_MRST),
        .en_i (cen_q),
        .d_i  (fetch_tag),
        .q_o  (out_tag)
    );

    assign o_VIDEO_CEN = cen_q;

    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_MRST) begin
        if (i_EMU_MRST) begin
            div_q         <= 3'd0;
            cen_q         <= 1'b0;
            h_q           <= 9'd0;
            v_q           <= 9'(V_ACTIVE);
            pattern_q     <= PatFb;
            o_FB_ADDR     <= 16'd0;
            o_FB_RD       <= 1'b0;
            o_VIDEO_EN    <= 1'b0;
            o_VIDEO_R     <= 3'd0;
            o_VIDEO_G     <= 3'd0;
            o_VIDEO_B     <= 3'd0;
            o_HSYNC       <= 1'b0;
            o_VSYNC       <= 1'b0;
            o_VBLANK      <= 1'b0;
            o_FRAME_START <= 1'b0;
        end else begin
            div_q <= div_d;
            cen_q <= (div_d == 3'(CEN_DIV - 1));
            if (cen_q) begin
                o_FB_ADDR <= {v_q[7:0], h_q[7:0]};
                o_FB_RD   <= fetch_tag.active;
                // Latching at the first fetch of a frame keeps a whole frame on one source.
                if (fetch_tag.frame_start) begin
                    pattern_q <= pattern_t'(i_PATTERN);
                end
                if (h_q == 9'(H_TOTAL - 1)) begin
                    h_q <= 9'd0;
                    v_q <= (v_q == 9'(V_TOTAL - 1)) ? 9'd0 : v_q + 9'd1;
                end else begin
                    h_q <= h_q + 9'd1;
                end

                o_VIDEO_EN    <= out_tag.active;
                o_HSYNC       <= out_tag.hsync;
                o_VSYNC       <= out_tag.vsync;
                o_VBLANK      <= out_tag.vblank;
                o_FRAME_START <= out_tag.frame_start;
                {o_VIDEO_R, o_VIDEO_G, o_VIDEO_B} <= out_tag.active ? pix : 9'd0;
            end
        end
    end

endmodule

// File: tb/tb_suprloco_video_tx.sv
// Directed, table-driven bench for suprloco_video_tx on a shortened frame (12 of 14 lines active).
module tb_suprloco_video_tx;

    localparam int CEN_DIV     = 3;
    localparam int H_ACTIVE    = 256;
    localparam int H_TOTAL     = 320;
    localparam int V_ACTIVE    = 12;
    localparam int V_TOTAL     = 14;
    localparam int FB_LATENCY  = 2;
    localparam int FRAME_TICKS = H_TOTAL * V_TOTAL;
    localparam int BLANK_TICKS = (V_TOTAL - V_ACTIVE) * H_TOTAL;
    localparam int RST_IDX     = 10 * H_TOTAL + 118;  // output position whose fetch is (120,10)

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  pat = 2'd1;
    logic [15:0] o_FB_ADDR;
    logic        o_FB_RD;
    logic [8:0]  fb_d1;
    logic        o_VIDEO_CEN, o_VIDEO_EN, o_HSYNC, o_VSYNC, o_VBLANK, o_FRAME_START;
    logic [2:0]  o_VIDEO_R, o_VIDEO_G, o_VIDEO_B;

    int errors = 0;
    int checks = 0;

    suprloco_video_tx #(
        .CEN_DIV(CEN_DIV), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE),
        .V_TOTAL(V_TOTAL), .FB_LATENCY(FB_LATENCY), .HS_START(272), .HS_END(303),
        .VS_START(12), .VS_END(12)
    ) dut (
        .i_EMU_MCLK(clk), .i_EMU_MRST(rst), .i_PATTERN(pat),
        .o_FB_ADDR(o_FB_ADDR), .o_FB_RD(o_FB_RD), .i_FB_DATA(fb_d1),
        .o_VIDEO_CEN(o_VIDEO_CEN), .o_VIDEO_EN(o_VIDEO_EN),
        .o_VIDEO_R(o_VIDEO_R), .o_VIDEO_G(o_VIDEO_G), .o_VIDEO_B(o_VIDEO_B),
        .o_HSYNC(o_HSYNC), .o_VSYNC(o_VSYNC), .o_VBLANK(o_VBLANK),
        .o_FRAME_START(o_FRAME_START)
    );

    always #5 clk = ~clk;

    // Framebuffer model: registered read, data returns addr[8:0] two ticks after the address.
    always @(posedge clk) begin
        if (o_VIDEO_CEN) fb_d1 <= o_FB_ADDR[8:0];
    end

    int cen_gap = 0, cen_seen = 0, cen_bad = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cen_gap  <= 0;
            cen_seen <= 0;
        end else if (o_VIDEO_CEN) begin
            if (cen_seen > 0 && cen_gap != CEN_DIV - 1) cen_bad <= cen_bad + 1;
            cen_gap  <= 0;
            cen_seen <= cen_seen + 1;
        end else begin
            cen_gap <= cen_gap + 1;
        end
    end

    typedef struct {
        int          f;
        int          x;
        int          y;
        logic [3:0]  flags;  // {en, hsync, vsync, vblank}
        logic [8:0]  rgb;
        logic        chk_fb;
        logic [15:0] addr;
        logic        rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int f, int x, int y, logic [3:0] flags, logic [8:0] rgb,
                                logic chk_fb = 1'b0, logic [15:0] addr = 16'h0,
                                logic rd = 1'b0);
        vec_t v;
        v.f = f; v.x = x; v.y = y; v.flags = flags; v.rgb = rgb;
        v.chk_fb = chk_fb; v.addr = addr; v.rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return {o_VIDEO_CEN, o_VIDEO_EN, o_VIDEO_R, o_VIDEO_G, o_VIDEO_B, o_HSYNC, o_VSYNC,
                o_VBLANK, o_FRAME_START, o_FB_RD, o_FB_ADDR};
    endfunction

    task automatic tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_VIDEO_CEN !== 1'b1 && n < 4 * CEN_DIV);
        if (o_VIDEO_CEN !== 1'b1) begin
            $display("FAIL tick_timeout: no o_VIDEO_CEN within %0d MCLKs", n);
            $fatal(1, "pixel enable stalled");
        end
        @(posedge clk);
        #1;
    endtask

    // Called at a negedge right after reset release; returns the MCLK edge count to the first tick.
    task automatic first_cen(output int n);
        logic c = 1'b0;
        n = 0;
        while (!c && n < 20) begin
            c = o_VIDEO_CEN;
            @(posedge clk);
            n++;
            #1;
        end
    endtask

    task automatic wait_frame_start(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (o_FRAME_START !== 1'b1 && n < FRAME_TICKS + 10);
    endtask

    int n, f, idx, x, y, en_cnt, en_bad, applied;
    logic done;

    initial begin
        // Frame 1 bars
        vecs.push_back(mk(1,   0,  0, 4'b1000, 9'o000));
        vecs.push_back(mk(1,  31,  0, 4'b1000, 9'o000));
        vecs.push_back(mk(1,  32,  0, 4'b1000, 9'o007));
        vecs.push_back(mk(1,  63,  5, 4'b1000, 9'o007));
        vecs.push_back(mk(1,  64,  0, 4'b1000, 9'o070));
        vecs.push_back(mk(1, 160,  3, 4'b1000, 9'o707));
        vecs.push_back(mk(1, 224,  0, 4'b1000, 9'o777));
        vecs.push_back(mk(1, 253,  0, 4'b1000, 9'o777, 1'b1, 16'h00ff, 1'b1));
        vecs.push_back(mk(1, 254,  0, 4'b1000, 9'o777, 1'b1, 16'h0000, 1'b0));
        vecs.push_back(mk(1, 255, 11, 4'b1000, 9'o777));
        vecs.push_back(mk(1, 256,  0, 4'b0000, 9'o000));
        vecs.push_back(mk(1, 271,  0, 4'b0000, 9'o000));
        vecs.push_back(mk(1, 272,  0, 4'b0100, 9'o000));
        vecs.push_back(mk(1, 303,  2, 4'b0100, 9'o000));
        vecs.push_back(mk(1, 304,  2, 4'b0000, 9'o000));
        vecs.push_back(mk(1,   0, 12, 4'b0011, 9'o000));
        vecs.push_back(mk(1, 100, 13, 4'b0001, 9'o000));
        // Frame 2 framebuffer
        vecs.push_back(mk(2,   0,  0, 4'b1000, 9'o000));
        vecs.push_back(mk(2,   3, 10, 4'b1000, 9'o003, 1'b1, 16'h0a05, 1'b1));
        vecs.push_back(mk(2,   5, 10, 4'b1000, 9'o005));
        vecs.push_back(mk(2,  17,  3, 4'b1000, 9'o421));
        vecs.push_back(mk(2, 255, 11, 4'b1000, 9'o777));
        vecs.push_back(mk(2, 256,  1, 4'b0000, 9'o000));
        // Frame 3 checker, bars requested at line 6
        vecs.push_back(mk(3,   0,  0, 4'b1000, 9'o000));
        vecs.push_back(mk(3,   8,  0, 4'b1000, 9'o777));
        vecs.push_back(mk(3,   8,  8, 4'b1000, 9'o000));
        vecs.push_back(mk(3,   0,  8, 4'b1000, 9'o777));
        vecs.push_back(mk(3,  15,  9, 4'b1000, 9'o000));
        vecs.push_back(mk(3,  16,  9, 4'b1000, 9'o777));
        // Frame 4 bars
        vecs.push_back(mk(4,   0,  8, 4'b1000, 9'o000));
        vecs.push_back(mk(4,  40,  8, 4'b1000, 9'o007));
        vecs.push_back(mk(4, 100,  9, 4'b1000, 9'o077));
        vecs.push_back(mk(4, 255,  0, 4'b1000, 9'o777));

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 32'h0);
        rst = 1'b0;
        first_cen(n);
        check("first_cen_edge", n, CEN_DIV);
        wait_frame_start(n);
        check("first_frame_start", n, BLANK_TICKS + FB_LATENCY);

        f = 1; idx = 0; en_cnt = 0; en_bad = 0; applied = 0; done = 1'b0;
        while (!done) begin
            x = idx % H_TOTAL;
            y = idx / H_TOTAL;
            if (o_VIDEO_EN) en_cnt++;
            if (o_VIDEO_EN !== ((x < H_ACTIVE) && (y < V_ACTIVE))) en_bad++;
            foreach (vecs[i]) begin
                if (vecs[i].f == f && vecs[i].x == x && vecs[i].y == y) begin
                    applied++;
                    check($sformatf("f%0d_x%0d_y%0d_flags", f, x, y),
                          {o_VIDEO_EN, o_HSYNC, o_VSYNC, o_VBLANK}, vecs[i].flags);
                    check($sformatf("f%0d_x%0d_y%0d_rgb", f, x, y),
                          {o_VIDEO_R, o_VIDEO_G, o_VIDEO_B}, vecs[i].rgb);
                    if (vecs[i].chk_fb) begin
                        check($sformatf("f%0d_x%0d_y%0d_fb", f, x, y),
                              {o_FB_RD, o_FB_ADDR}, {vecs[i].rd, vecs[i].addr});
                    end
                end
            end
            if (idx == 12 * H_TOTAL && f == 1) pat = 2'd0;
            if (idx == 12 * H_TOTAL && f == 2) pat = 2'd2;
            if (idx == 6 * H_TOTAL && f == 3) pat = 2'd1;
            if (f == 4 && idx == RST_IDX) begin
                done = 1'b1;
            end else begin
                tick();
                idx++;
                if (o_FRAME_START === 1'b1) begin
                    check($sformatf("f%0d_frame_period", f), idx, FRAME_TICKS);
                    check($sformatf("f%0d_en_count", f), en_cnt, H_ACTIVE * V_ACTIVE);
                    check($sformatf("f%0d_en_map", f), en_bad, 0);
                    f++; idx = 0; en_cnt = 0; en_bad = 0;
                end else if (idx > FRAME_TICKS + 8) begin
                    check("frame_start_timeout", idx, FRAME_TICKS);
                    done = 1'b1;
                end
            end
        end
        check("vectors_applied", applied, vecs.size());

        // Mid-frame asynchronous reset, asserted between clock edges
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", all_outputs(), 32'h0);
        repeat (3) @(posedge clk);
        #1 check("reset_hold_outputs", all_outputs(), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        first_cen(n);
        check("post_reset_first_cen_edge", n, CEN_DIV);
        wait_frame_start(n);
        check("post_reset_frame_start", n, BLANK_TICKS + FB_LATENCY);
        repeat (40) tick();
        check("post_reset_bar_x40", {o_VIDEO_EN, o_VIDEO_R, o_VIDEO_G, o_VIDEO_B}, {1'b1, 9'o007});

        check("cen_period_violations", cen_bad, 0);
        check("cen_activity", cen_seen > 100, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
